alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the main execute stage, requester 1 is the branch/address unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The arbiter drives the ALU operand and opcode inputs, captures the ALU result into a per-requester one-entry response buffer, and returns it one cycle after grant.
- Arbitration is round-robin or fixed-priority with an anti-starvation timeout.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority, requester 0 highest.
- MAX_WAIT, 8: fixed mode only. Number of consecutive cycles requester 1 may be denied while valid before it is force-granted. Range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req0_valid_i  in  1  requester 0 request valid
- req0_ready_o  out  1  requester 0 request accepted this cycle
- req0_a_i  in  data_t  operand A
- req0_b_i  in  data_t  operand B
- req0_op_i  in  alu_op_e  operation
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_op_i: same as requester 0, for requester 1
- rsp0_valid_o  out  1  requester 0 result valid
- rsp0_ready_i  in  1  requester 0 consumes result
- rsp0_result_o  out  data_t  registered ALU result
- rsp0_zero_o  out  1  registered ALU zero flag
- rsp1_valid_o, rsp1_ready_i, rsp1_result_o, rsp1_zero_o: same as requester 0, for requester 1
- alu_a_o  out  data_t  to ALU operand A
- alu_b_o  out  data_t  to ALU operand B
- alu_op_o  out  alu_op_e  to ALU opcode
- alu_result_i  in  data_t  from ALU result
- alu_zero_i  in  1  from ALU zero flag

Behaviour:
- Reset (asynchronous, active-high):
  - rsp*_valid_o = 0; rsp*_result_o = 0; rsp*_zero_o = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - wait counter = 0.
  - req*_ready_o = 0 while rst_i is high.
- Eligibility:
  - Requester k is eligible when reqk_valid_i = 1 AND (rspk_valid_o = 0 OR rspk_ready_i = 1).
  - A full buffer that drains in the same cycle may accept a new request.
- Grant is combinational; at most one grant per cycle.
  - Round-robin: if both are eligible, grant the one not equal to last_grant. last_grant updates only on a grant.
  - Fixed: grant requester 0 if eligible, else requester 1. Exception: if wait counter = MAX_WAIT and requester 1 is eligible, grant requester 1.
  - Wait counter: increments (saturating at 255) when requester 1 is valid and not granted. Clears on any requester-1 grant, or when req1_valid_i = 0. Held at 0 in round-robin mode.
- Outputs for the granted requester k:
  - reqk_ready_o = 1.
  - alu_a_o, alu_b_o, alu_op_o = requester k inputs.
- With no grant: alu_a_o = 0, alu_b_o = 0, alu_op_o = ALU_ADD.
- Latency: the request handshake at edge N loads alu_result_i and alu_zero_i into buffer k. rspk_valid_o = 1 from cycle N+1.
- Response buffer update:
  - Holds its value while rspk_valid_o = 1 and rspk_ready_i = 0.
  - Clears valid on handshake unless reloaded in the same cycle; reload takes precedence.
- Throughput: one operation per cycle total. Back-to-back grants to the same requester are allowed when its consumer keeps rspk_ready_i = 1.
- Opcode values outside the defined set pass through unchanged; the ALU returns 0 and the buffer records zero = 1.
- Requesters must hold valid, operands and op stable until ready. The arbiter does not register requests.
- Reset asserted mid-operation discards buffered results. No response is produced for a request accepted in the same cycle reset asserts.

Test Plan:
- Single requester: req0 ADD a=5, b=7 with rsp0_ready_i = 1 -> req0_ready_o = 1 in cycle 0; rsp0_valid_o = 1, result = 12, zero = 0 in cycle 1.
- Round-robin contention (PRIORITY_MODE = 0): both valid continuously, all response readies = 1 -> grants alternate 0,1,0,1 starting with requester 0. Requester 1 is SUB 3−3 and returns result 0, zero = 1.
- Backpressure: req0 SLT −1<1 with rsp0_ready_i = 0 -> rsp0 holds result 1. A second req0 is not accepted until rsp0_ready_i = 1. Requester 1 is granted in the meantime.
- Fixed-priority starvation (PRIORITY_MODE = 1, MAX_WAIT = 3): both valid continuously -> requester 0 granted 3 cycles, requester 1 granted on cycle 4, then pattern repeats.
- Drain-and-refill: rsp1 full with rsp1_ready_i = 1 and req1 SRA 0x80000000>>4 valid in the same cycle -> accepted. Next cycle rsp1_result_o = 0xF8000000 with rsp1_valid_o held at 1.
- Reset mid-stream: assert rst_i while rsp0 is valid -> rsp0_valid_o = 0 immediately (asynchronous) and req*_ready_o = 0. After release, requester 0 wins the first tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU
//
// Purpose: grants one of two valid/ready requesters per cycle, drives the
// shared ALU with the winner's operands and captures the ALU result into
// that requester's one-entry response buffer.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   req{0,1}_valid_i/_ready_o        request handshake (0 = execute, 1 = branch/addr)
//   req{0,1}_a_i/_b_i/_op_i          operands and opcode, held stable until ready
//   rsp{0,1}_valid_o/_ready_i        response handshake
//   rsp{0,1}_result_o/_zero_o        registered ALU result and zero flag
//   alu_a_o/_b_o/_op_o               to the shared ALU
//   alu_result_i/_zero_i             from the shared ALU
module alu_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 8,
  parameter int DATA_W        = 32,
  parameter int OP_W          = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,

  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic              rsp0_zero_o,

  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic              rsp1_zero_o,

  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  localparam logic [OP_W-1:0] ALU_ADD    = '0;
  localparam logic [7:0]      MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic            FIXED_PRIO = (PRIORITY_MODE == 1);

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
  logic              rsp0_zero_q, rsp0_zero_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
  logic              rsp1_zero_q, rsp1_zero_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        wait_q, wait_d;

  logic elig0, elig1;
  logic gnt0, gnt1;

  // A full buffer that is draining this cycle can take a new result.
  assign elig0 = req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
  assign elig1 = req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (FIXED_PRIO) begin
        // Forced grant only fires on the exact count; a starved requester 1
        // that was ineligible past MAX_WAIT falls back to plain priority.
        if (elig1 && (wait_q == MAX_WAIT_C)) begin
          gnt1 = 1'b1;
        end else if (elig0) begin
          gnt0 = 1'b1;
        end else if (elig1) begin
          gnt1 = 1'b1;
        end
      end else begin
        if (elig0 && elig1) begin
          // Tie goes to whoever did not win last.
          gnt0 = last_grant_q;
          gnt1 = !last_grant_q;
        end else begin
          gnt0 = elig0;
          gnt1 = elig1;
        end
      end
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_ADD;
    if (gnt0) begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_op_o = req0_op_i;
    end else if (gnt1) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_op_o = req1_op_i;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!FIXED_PRIO) begin
      wait_d = 8'd0;
    end else if (!req1_valid_i || gnt1) begin
      wait_d = 8'd0;
    end else if (wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Reload wins over a same-cycle drain, so valid stays high on refill.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    if (gnt0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result_i;
      rsp0_zero_d   = alu_zero_i;
    end else if (rsp0_valid_q && rsp0_ready_i) begin
      rsp0_valid_d  = 1'b0;
    end
  end

  always_comb begin
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    if (gnt1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result_i;
      rsp1_zero_d   = alu_zero_i;
    end else if (rsp1_valid_q && rsp1_ready_i) begin
      rsp1_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      last_grant_q  <= 1'b1;
      wait_q        <= 8'd0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      last_grant_q  <= last_grant_d;
      wait_q        <= wait_d;
    end
  end

  assign rsp0_valid_o  = rsp0_valid_q;
  assign rsp0_result_o = rsp0_result_q;
  assign rsp0_zero_o   = rsp0_zero_q;
  assign rsp1_valid_o  = rsp1_valid_q;
  assign rsp1_result_o = rsp1_result_q;
  assign rsp1_zero_o   = rsp1_zero_q;

endmodule
